// File: rtl/mem_arbiter.sv
// Two-requester (CPU / loader) single-port memory arbiter with a three-state FSM.
// Optional feature: define ARB_STALL_COUNT_EN to add the stall_cnt output and its counter.
module mem_arbiter (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    input  logic        ld_req,
    input  logic        ld_we,
    input  logic [15:0] ld_addr,
    input  logic [15:0] ld_wdata,
    output logic        ld_ack,
    output logic [15:0] ld_rdata,
    input  logic        ld_prio,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy
`ifdef ARB_STALL_COUNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, GRANT, RESP} state_e;
    typedef enum logic {ID_CPU, ID_LD} req_id_e;

    state_e      state_q;
    req_id_e     win_q;
    req_id_e     last_grant_q;
    logic        we_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        cpu_ack_q;
    logic        ld_ack_q;
    logic [15:0] cpu_rdata_q;
    logic [15:0] ld_rdata_q;

    logic        any_req_d;
    req_id_e     win_d;
    logic        we_d;
    logic [15:0] addr_d;
    logic [15:0] wdata_d;

    // Loader wins when alone, when prioritised, or when the CPU had the last grant.
    always_comb begin
        any_req_d = cpu_req | ld_req;
        win_d     = ID_CPU;
        if (ld_req && (!cpu_req || ld_prio || (last_grant_q == ID_CPU))) begin
            win_d = ID_LD;
        end
        if (win_d == ID_LD) begin
            we_d    = ld_we;
            addr_d  = ld_addr;
            wdata_d = ld_wdata;
        end else begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= IDLE;
            win_q        <= ID_CPU;
            last_grant_q <= ID_LD;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_ack_q    <= 1'b0;
            ld_ack_q     <= 1'b0;
            cpu_rdata_q  <= '0;
            ld_rdata_q   <= '0;
        end else begin
            cpu_ack_q <= 1'b0;
            ld_ack_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (any_req_d) begin
                        state_q <= GRANT;
                        win_q   <= win_d;
                        we_q    <= we_d;
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                    end
                end
                GRANT: begin
                    state_q <= RESP;
                end
                RESP: begin
                    // mem_rdata is valid now, one cycle after the GRANT strobe.
                    state_q      <= IDLE;
                    last_grant_q <= win_q;
                    if (win_q == ID_LD) begin
                        ld_ack_q <= 1'b1;
                        if (!we_q) begin
                            ld_rdata_q <= mem_rdata;
                        end
                    end else begin
                        cpu_ack_q <= 1'b1;
                        if (!we_q) begin
                            cpu_rdata_q <= mem_rdata;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_en    = (state_q == GRANT);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != IDLE);
    assign cpu_ack   = cpu_ack_q;
    assign ld_ack    = ld_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ld_rdata  = ld_rdata_q;

`ifdef ARB_STALL_COUNT_EN
    logic [15:0] stall_q;
    logic        serving_cpu;

    assign serving_cpu = (state_q != IDLE) && (win_q == ID_CPU);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            stall_q <= '0;
        end else if (cpu_req && !serving_cpu && (stall_q != '1)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule
